// File: rtl/elevator_ctrl_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_ctrl_scan_if
// Brief    : Call-button / car-status bundle between the tt_um wrapper side
//            (master) and the SCAN elevator controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface elevator_ctrl_scan_if #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
);
  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  dir_up;
  logic                  moving;
  logic                  door_open;
  logic                  arrived;
  logic [NUM_FLOORS-1:0] pending;

  // Wrapper / button side: issues calls, observes car status.
  modport master (
    output call_req,
    input  current_floor, dir_up, moving, door_open, arrived, pending
  );

  // Controller side: consumes calls, reports car status.
  modport slave (
    input  call_req,
    output current_floor, dir_up, moving, door_open, arrived, pending
  );
endinterface
`default_nettype wire

// File: rtl/elevator_ctrl_scan.sv
`default_nettype none
// ============================================================================
// Module   : elevator_ctrl_scan
// Brief    : Single-car elevator controller for NUM_FLOORS floors. Latches
//            per-floor calls and serves them in SCAN order: keep going in the
//            current direction while calls remain ahead, then reverse.
//            Optional emergency stop is compiled in with ELEVATOR_ESTOP_EN,
//            which adds the 'estop' input (freeze state/timer, keep latching).
// Revision : 1.0 - initial release
// ============================================================================
module elevator_ctrl_scan #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic clk,
  input  logic rst,
`ifdef ELEVATOR_ESTOP_EN
  input  logic estop,
`endif
  elevator_ctrl_scan_if.slave bus
);

  // Timer must hold the larger of the two reload values.
  localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TIMER_W-1:0] TRAVEL_RELOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_RELOAD   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR     = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [TIMER_W-1:0]    timer, timer_nxt;
  logic [FLOOR_W-1:0]    cur_floor, floor_nxt, nf;
  logic                  dir, dir_nxt;
  logic [NUM_FLOORS-1:0] pend, pend_nxt, eff;
  logic                  arrived_q, arrived_nxt;
  logic                  moving_q, moving_nxt;
  logic                  door_q, door_nxt;

  // True when any request lies strictly beyond 'fl' in direction 'up'.
  // At the top floor going up (or floor 0 going down) this is empty.
  function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]    fl,
                                       input logic                  up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (req[i] && (up ? (i > int'(fl)) : (i < int'(fl))))
        r = 1'b1;
    end
    return r;
  endfunction

  // State, timer, position and all outputs update together on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      cur_floor <= '0;
      dir       <= 1'b1;
      pend      <= '0;
      arrived_q <= 1'b0;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      cur_floor <= floor_nxt;
      dir       <= dir_nxt;
      pend      <= pend_nxt;
      arrived_q <= arrived_nxt;
      moving_q  <= moving_nxt;
      door_q    <= door_nxt;
    end
  end

  // SCAN scheduling: next state, timer, floor, direction and latched calls.
  always_comb begin
    eff         = pend | bus.call_req;
    state_nxt   = state;
    timer_nxt   = timer;
    floor_nxt   = cur_floor;
    dir_nxt     = dir;
    pend_nxt    = eff;
    arrived_nxt = 1'b0;
    nf          = cur_floor;

    case (state)
      IDLE: begin
        if (eff[cur_floor]) begin
          // Call at the car's own floor: open immediately, never latch it.
          state_nxt           = DOOR_OPEN;
          timer_nxt           = DOOR_RELOAD;
          pend_nxt[cur_floor] = 1'b0;
          arrived_nxt         = 1'b1;
        end else if (calls_ahead(eff, cur_floor, dir)) begin
          state_nxt = MOVING;
          timer_nxt = TRAVEL_RELOAD;
        end else if (calls_ahead(eff, cur_floor, ~dir)) begin
          dir_nxt   = ~dir;
          state_nxt = MOVING;
          timer_nxt = TRAVEL_RELOAD;
        end
      end

      MOVING: begin
        if (timer != '0) begin
          timer_nxt = timer - TIMER_W'(1);
        end else begin
          // One floor travelled; clamp keeps the car inside the shaft even
          // though MOVING is only entered with a call ahead.
          if (dir)
            nf = (cur_floor == TOP_FLOOR) ? cur_floor : cur_floor + FLOOR_W'(1);
          else
            nf = (cur_floor == '0) ? cur_floor : cur_floor - FLOOR_W'(1);
          floor_nxt = nf;
          if (eff[nf]) begin
            state_nxt    = DOOR_OPEN;
            timer_nxt    = DOOR_RELOAD;
            pend_nxt[nf] = 1'b0;
            arrived_nxt  = 1'b1;
          end else if (calls_ahead(eff, nf, dir)) begin
            timer_nxt = TRAVEL_RELOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      DOOR_OPEN: begin
        // A press for the open floor holds the door rather than latching.
        pend_nxt[cur_floor] = pend[cur_floor];
        if (bus.call_req[cur_floor])
          timer_nxt = DOOR_RELOAD;
        else if (timer == '0)
          state_nxt = IDLE;
        else
          timer_nxt = timer - TIMER_W'(1);
      end

      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

`ifdef ELEVATOR_ESTOP_EN
    // Emergency stop: freeze everything except call latching.
    if (estop) begin
      state_nxt   = state;
      timer_nxt   = timer;
      floor_nxt   = cur_floor;
      dir_nxt     = dir;
      pend_nxt    = pend | bus.call_req;
      arrived_nxt = 1'b0;
    end
    moving_nxt = (state_nxt == MOVING) && !estop;
`else
    moving_nxt = (state_nxt == MOVING);
`endif
    door_nxt = (state_nxt == DOOR_OPEN);
  end

  assign bus.current_floor = cur_floor;
  assign bus.dir_up        = dir;
  assign bus.moving        = moving_q;
  assign bus.door_open     = door_q;
  assign bus.arrived       = arrived_q;
  assign bus.pending       = pend;

endmodule
`default_nettype wire
